// File: rtl/trafik_isigi_izleyici.sv
// Reader/checker for the active-low 3-bit traffic-light LED bus: synchronises and
// debounces the pattern, decodes the phase, measures dwell time and flags protocol errors.
module trafik_isigi_izleyici #(
    parameter int                 STABLE_CYCLES = 4,
    parameter int                 DWELL_W       = 32,
    parameter logic [DWELL_W-1:0] MAX_DWELL     = 32'd96_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [2:0]         led_in,
    input  logic               err_clear,
    output logic [1:0]         phase,
    output logic               phase_valid,
    output logic               phase_done,
    output logic [1:0]         last_phase,
    output logic [DWELL_W-1:0] last_dwell,
    output logic               err_pattern,
    output logic               err_order,
    output logic               err_timeout
);

    localparam int                 CNT_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] DWELL_SAT = {DWELL_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RED   = 3'd1,
        S_BLUE  = 3'd2,
        S_GREEN = 3'd3,
        S_BAD   = 3'd4
    } state_t;

    function automatic logic is_colour(input state_t s);
        case (s)
            S_RED, S_BLUE, S_GREEN: is_colour = 1'b1;
            default:                is_colour = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] phase_code(input state_t s);
        case (s)
            S_RED:   phase_code = 2'b01;
            S_BLUE:  phase_code = 2'b10;
            S_GREEN: phase_code = 2'b11;
            default: phase_code = 2'b00;
        endcase
    endfunction

    logic [2:0]         sync1_q, sync2_q, cand_q, cand_d, acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_chg_q, acc_chg_d;
    state_t             state_q, dec_s;
    logic [DWELL_W-1:0] dwell_q, last_dwell_q;
    logic [1:0]         phase_q, last_phase_q;
    logic               phase_valid_q, phase_done_q, to_fired_q;
    logic               err_pattern_q, err_order_q, err_timeout_q;
    logic               order_ok_s, pat_set_s, order_set_s, to_set_s;

    // Glitch filter next state: a new candidate restarts the count, acceptance on reaching the limit
    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        acc_chg_d = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        if ((cnt_d == CNT_MAX) && (cand_d != acc_q)) begin
            acc_d     = cand_d;
            acc_chg_d = 1'b1;
        end else begin
            acc_d     = acc_q;
            acc_chg_d = 1'b0;
        end
    end

    // Synchroniser and filter registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q   <= 3'b111;
            sync2_q   <= 3'b111;
            cand_q    <= 3'b111;
            acc_q     <= 3'b111;
            cnt_q     <= '0;
            acc_chg_q <= 1'b0;
        end else begin
            sync1_q   <= led_in;
            sync2_q   <= sync1_q;
            cand_q    <= cand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            acc_chg_q <= acc_chg_d;
        end
    end

    // Decode accepted pattern and classify the pending transition
    always_comb begin
        case (acc_q)
            3'b101:  dec_s = S_RED;
            3'b011:  dec_s = S_BLUE;
            3'b110:  dec_s = S_GREEN;
            default: dec_s = S_BAD;
        endcase
        order_ok_s  = ((state_q == S_RED)   && (dec_s == S_BLUE))  ||
                      ((state_q == S_BLUE)  && (dec_s == S_GREEN)) ||
                      ((state_q == S_GREEN) && (dec_s == S_RED));
        pat_set_s   = acc_chg_q && (dec_s == S_BAD) && (state_q != S_BAD);
        order_set_s = acc_chg_q && is_colour(state_q) && is_colour(dec_s) && !order_ok_s;
        // Saturation keeps dwell at all-ones, so a one-shot flag stops a repeated raise
        to_set_s    = is_colour(state_q) && (dwell_q == MAX_DWELL) && !to_fired_q;
    end

    // Phase FSM with registered outputs, dwell counter and sticky error flags
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= S_IDLE;
            phase_q       <= 2'b00;
            phase_valid_q <= 1'b0;
            phase_done_q  <= 1'b0;
            last_phase_q  <= 2'b00;
            last_dwell_q  <= '0;
            dwell_q       <= '0;
            to_fired_q    <= 1'b0;
            err_pattern_q <= 1'b0;
            err_order_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            phase_done_q <= 1'b0;
            if (acc_chg_q) begin
                state_q    <= dec_s;
                to_fired_q <= 1'b0;
                if (is_colour(state_q)) begin
                    phase_done_q <= 1'b1;
                    last_phase_q <= phase_q;
                    last_dwell_q <= dwell_q;
                end
                if (is_colour(dec_s)) begin
                    dwell_q       <= DWELL_ONE;
                    phase_q       <= phase_code(dec_s);
                    phase_valid_q <= 1'b1;
                end else begin
                    dwell_q       <= '0;
                    phase_q       <= 2'b00;
                    phase_valid_q <= 1'b0;
                end
            end else begin
                if (to_set_s) begin
                    to_fired_q <= 1'b1;
                end
                if (is_colour(state_q) && (dwell_q != DWELL_SAT)) begin
                    dwell_q <= dwell_q + DWELL_ONE;
                end
            end
            err_pattern_q <= pat_set_s   ? 1'b1 : (err_clear ? 1'b0 : err_pattern_q);
            err_order_q   <= order_set_s ? 1'b1 : (err_clear ? 1'b0 : err_order_q);
            err_timeout_q <= to_set_s    ? 1'b1 : (err_clear ? 1'b0 : err_timeout_q);
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign phase_done  = phase_done_q;
    assign last_phase  = last_phase_q;
    assign last_dwell  = last_dwell_q;
    assign err_pattern = err_pattern_q;
    assign err_order   = err_order_q;
    assign err_timeout = err_timeout_q;

endmodule
